// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the clb_switch_box configuration loader:
// geometry helpers, FSM state encoding and the reset fill of the config vector.
package clb_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHK    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_RB     = 3'd4
    } cfg_state_e;

    // Every 2-bit mux select at 2'd3 means "no route".
    localparam logic CFG_RST_BIT = 1'b1;

    function automatic int cfg_width(input int ws, input int wd);
        return ws * 8 + (wd / 2) * 8;
    endfunction

    function automatic int cfg_nwords(input int cw, input int dw);
        return (cw + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/clb_cfg_shadow.sv
// Word-indexed shadow register for frame assembly, plus a word-indexed read
// mux and whole-vector word XOR used to stream a config vector back out.
module clb_cfg_shadow import clb_cfg_pkg::*; #(
    parameter int CW = 80,
    parameter int DW = 8,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [CW-1:0] shadow_o,
    input  logic [CW-1:0] rd_vec_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [DW-1:0] rd_word_o,
    output logic [DW-1:0] rd_xor_o
);

    logic [CW-1:0] shadow_q;
    logic [CW-1:0] shadow_d;

    // Bits of the last word that land at or above CW simply have no home.
    always_comb begin
        shadow_d = shadow_q;
        for (int b = 0; b < CW; b++) begin
            if (wr_en_i && ((b / DW) == int'(wr_idx_i))) begin
                shadow_d[b] = wr_data_i[b % DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // Pad bits of the last word read as 0, so the XOR matches a zero-padded frame.
    always_comb begin
        rd_word_o = '0;
        rd_xor_o  = '0;
        for (int b = 0; b < CW; b++) begin
            if ((b / DW) == int'(rd_idx_i)) begin
                rd_word_o[b % DW] = rd_vec_i[b];
            end
            rd_xor_o[b % DW] = rd_xor_o[b % DW] ^ rd_vec_i[b];
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/clb_switch_box_cfg_loader.sv
// Word-serial config writer for clb_switch_box: assembles a checksummed frame
// into a shadow register, commits it atomically to c, and streams c back out.
module clb_switch_box_cfg_loader import clb_cfg_pkg::*; #(
    parameter  int WS     = 7,
    parameter  int WD     = 6,
    parameter  int DW     = 8,
    localparam int CW     = cfg_width(WS, WD),
    localparam int NWORDS = cfg_nwords(CW, DW),
    localparam int IW     = $clog2(NWORDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          rb_start,
    output logic [DW-1:0] rb_data,
    output logic          rb_valid,
    input  logic          rb_ready,
    output logic [CW-1:0] c,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    dbg_state
);

    // Handshakes: a word moves on a rising edge where valid and ready are both
    // high; valid never waits on ready, and rb_data holds while stalled.
    cfg_state_e    state_q;
    logic [IW-1:0] cnt_q;
    logic [DW-1:0] acc_q;
    logic [CW-1:0] c_q;
    logic          done_q;
    logic          err_q;
    logic [CW-1:0] shadow;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] rd_xor;
    logic          sh_wr;

    // A restart cycle refuses the word on offer so it cannot leak into the new frame.
    assign in_ready = ((state_q == ST_LOAD) || (state_q == ST_CHK)) && !load_start;
    assign sh_wr    = (state_q == ST_LOAD) && in_ready && in_valid;
    assign rb_valid = (state_q == ST_RB);
    assign rb_data  = !rb_valid ? '0 : ((cnt_q == IW'(NWORDS)) ? rd_xor : rd_word);
    assign busy     = (state_q != ST_IDLE);

    clb_cfg_shadow #(
        .CW(CW),
        .DW(DW),
        .IW(IW)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (sh_wr),
        .wr_idx_i (cnt_q),
        .wr_data_i(in_data),
        .shadow_o (shadow),
        .rd_vec_i (c_q),
        .rd_idx_i (cnt_q),
        .rd_word_o(rd_word),
        .rd_xor_o (rd_xor)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            c_q     <= {CW{CFG_RST_BIT}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end else if (rb_start) begin
                        state_q <= ST_RB;
                        cnt_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                    end else if (in_valid) begin
                        acc_q <= acc_q ^ in_data;
                        cnt_q <= cnt_q + IW'(1);
                        if (cnt_q == IW'(NWORDS - 1)) begin
                            state_q <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end else if (in_valid) begin
                        if (in_data == acc_q) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    c_q     <= shadow;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_RB: begin
                    if (rb_ready) begin
                        if (cnt_q == IW'(NWORDS)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + IW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c         = c_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/clb_switch_box_cfg_loader.md
Name: clb_switch_box_cfg_loader

Overview:
Configuration writer for clb_switch_box. It accepts a word-serial bitstream over a valid/ready interface and assembles it into a shadow register. It checks an XOR checksum, then commits atomically to the parallel config vector c that drives the switch box. It also supports word-serial readback of the active config.

Parameters:
WS, 7, single-wire tracks per side (matches switch box)
WD, 6, double-wire tracks per side (matches switch box)
DW, 8, bitstream word width
Derived: CW = WS*8 + WD/2*8 (80 at defaults); NWORDS = ceil(CW/DW) (10 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, asynchronous active-low reset
load_start  in  1  begin/restart a load frame
in_data  in  DW  bitstream word
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a word
rb_start  in  1  begin readback of active config
rb_data  out  DW  readback word
rb_valid  out  1  rb_data valid
rb_ready  in  1  consumer accepts rb_data
c  out  CW  active config to clb_switch_box
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: new config committed
err  out  1  one-cycle pulse: checksum mismatch, frame discarded

Behaviour:
- Reset (async, rst_n=0): state IDLE, c = all ones (every 2-bit mux select = 2'd3, no route), shadow = 0, word count = 0, xor accumulator = 0. Outputs in_ready, rb_valid, busy, done, err are all 0; rb_data = 0. Deassertion takes effect at the next clk edge.
- States: IDLE, LOAD, CHK, COMMIT, RB.
- IDLE:
  - load_start -> LOAD, clearing count and accumulator.
  - Otherwise rb_start -> RB with count 0.
  - load_start has priority when both are asserted.
- LOAD:
  - in_ready = 1. A word is transferred on an edge with in_valid & in_ready.
  - Word i is written to shadow bits [i*DW +: DW]. Bits at or above CW in the last word are dropped.
  - The accumulator XORs in each full DW-bit word.
  - After word NWORDS-1 is accepted -> CHK.
- CHK:
  - in_ready = 1. The accepted word is the checksum.
  - If it equals the accumulator -> COMMIT. Otherwise -> IDLE and err=1 for the following cycle; c is unchanged.
- COMMIT: one cycle. At its closing edge c <= shadow, done=1 for exactly the next cycle, state -> IDLE. c changes only at this edge.
- load_start in LOAD or CHK restarts the frame: count=0, accumulator=0, and any word presented that cycle is not accepted (in_ready=0 that cycle). Partial shadow contents are don't-care.
- rb_start or load_start in RB is ignored. load_start in COMMIT is ignored.
- RB:
  - rb_valid = 1; rb_data = c word at index count, with pad bits 0.
  - Word index NWORDS carries the XOR of all NWORDS words, so the readback stream is a legal load frame.
  - Count advances on rb_valid & rb_ready. After word NWORDS is accepted -> IDLE.
  - rb_data is stable while rb_valid & !rb_ready.
- Minimum frame time: NWORDS+2 cycles from the first accepted word to done.
- in_ready is 0 in IDLE, COMMIT and RB. Words offered then are not consumed.
- Reset mid-frame returns to the reset state; c goes back to all ones.

Decomposition:
- Package clb_cfg_pkg holds:
  - CW and NWORDS as functions of WS, WD, DW
  - the state encoding: IDLE=0, LOAD=1, CHK=2, COMMIT=3, RB=4
  - the reset config value (all ones)
- One natural sub-module, clb_cfg_shadow: a word-indexed write of the CW-bit shadow register plus a word-indexed read mux for readback. It is shared by the load and RB paths.

Test Plan:
- Defaults. load_start, then words 0x00..0x09, then checksum 0x01, with in_valid held high -> done pulses 12 cycles after the first accept; c = 80'h09080706050403020100; err=0.
- Same frame but checksum 0x02 -> err pulses once, done=0, c keeps its prior value (all ones after reset).
- Random in_valid gaps plus load_start re-asserted after word 4, followed by a full valid frame -> only the second frame commits; the word offered on the restart cycle is not consumed.
- After a commit, rb_start with rb_ready toggling randomly -> 11 words 0x00..0x09, 0x01 in order. rb_data is stable while stalled. The captured stream is fed back as a load frame -> done, c unchanged.
- rst_n pulled low during CHK -> c=all ones, busy=0, in_ready=0 immediately (asynchronous), no done or err.
- WS=7, WD=6 with DW=3 (NWORDS=27): the last word's upper bit is dropped from c but included in the checksum. Pair with a clb_switch_box instance and a random config -> every mux output matches the select implied by the committed c.
